// File: rtl/painter_pkg.sv
// Shared types and constants for the canvas painter.
package painter_pkg;

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam int COLOR_W = 3;
  typedef logic [COLOR_W-1:0] color_t;

  localparam int RD_LAT = 2;

  localparam color_t BLACK = '0;
  localparam color_t WHITE = '1;

endpackage

// File: rtl/canvas_ram.sv
// Simple dual-port canvas store: sync write, sync read-first read.
module canvas_ram
  import painter_pkg::*;
#(
  parameter int DEPTH = 19200,
  parameter int AW    = 15,
  parameter int DW    = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:DEPTH-1];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/canvas_painter.sv
// Cell canvas with clamped cursor, pen and clear sequencer.
// CURSOR_OVERLAY_EN: invert the cell under the cursor on display.
module canvas_painter
  import painter_pkg::*;
#(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int CELL_LOG2  = 2,
  parameter int COLOR_BITS = 3,
  parameter int MOVE_DIV   = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_up,
  input  logic btn_dn,
  input  logic btn_lf,
  input  logic btn_rt,
  input  logic pen_down,
  input  logic [COLOR_BITS-1:0] pen_color,
  input  logic clear_req,
  input  logic [9:0] pix_x,
  input  logic [8:0] pix_y,
  input  logic pix_valid,
  input  logic hsync_in,
  input  logic vsync_in,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b,
  output logic hsync_out,
  output logic vsync_out,
  output logic [$clog2(H_ACTIVE>>CELL_LOG2)-1:0] cursor_x,
  output logic [$clog2(V_ACTIVE>>CELL_LOG2)-1:0] cursor_y,
  output logic busy
);

  localparam int CANVAS_W = H_ACTIVE >> CELL_LOG2;
  localparam int CANVAS_H = V_ACTIVE >> CELL_LOG2;
  localparam int DEPTH    = CANVAS_W * CANVAS_H;
  localparam int AW       = $clog2(DEPTH);
  localparam int CXW      = $clog2(CANVAS_W);
  localparam int CYW      = $clog2(CANVAS_H);

  state_t state_q, state_d;
  logic [AW-1:0] clr_q, clr_d;
  logic [MOVE_DIV-1:0] cnt_q, cnt_d;
  logic [CXW-1:0] cx_q, cx_d, nx;
  logic [CYW-1:0] cy_q, cy_d, ny;
  logic tick;

  logic we;
  logic [AW-1:0] waddr;
  logic [COLOR_BITS-1:0] wdata;

  logic [AW-1:0] raddr_q, raddr_d;
  logic [RD_LAT-1:0] v_q, v_d;
  logic [RD_LAT-1:0] hs_q, hs_d;
  logic [RD_LAT-1:0] vs_q, vs_d;
  logic [COLOR_BITS-1:0] rdata, pix;

  assign tick  = (cnt_q == '0);
  assign cnt_d = cnt_q + MOVE_DIV'(1);

  // Opposing buttons cancel; edges clamp rather than wrap.
  always_comb begin
    nx = cx_q;
    ny = cy_q;
    if (btn_rt && !btn_lf && cx_q != CXW'(CANVAS_W-1))
      nx = cx_q + CXW'(1);
    else if (btn_lf && !btn_rt && cx_q != '0)
      nx = cx_q - CXW'(1);
    if (btn_dn && !btn_up && cy_q != CYW'(CANVAS_H-1))
      ny = cy_q + CYW'(1);
    else if (btn_up && !btn_dn && cy_q != '0)
      ny = cy_q - CYW'(1);
  end

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    we      = 1'b0;
    waddr   = clr_q;
    wdata   = COLOR_BITS'(BLACK);
    unique case (state_q)
      CLEAR: begin
        we    = 1'b1;
        clr_d = clr_q + AW'(1);
        if (clr_q == AW'(DEPTH-1)) begin
          state_d = IDLE;
          clr_d   = '0;
        end
      end
      IDLE: begin
        if (tick) begin
          cx_d = nx;
          cy_d = ny;
          if (pen_down) begin
            we    = 1'b1;
            waddr = AW'(ny) * AW'(CANVAS_W) + AW'(nx);
            wdata = pen_color;
          end
        end
        if (clear_req) begin
          state_d = CLEAR;
          clr_d   = '0;
        end
      end
      default: ;
    endcase
  end

  // Off-screen scans read address 0 so the RAM never sees an out-of-range index.
  always_comb begin
    raddr_d = '0;
    if (pix_valid)
      raddr_d = AW'(pix_y >> CELL_LOG2) * AW'(CANVAS_W)
              + AW'(pix_x >> CELL_LOG2);
    v_d  = {v_q[RD_LAT-2:0], pix_valid};
    hs_d = {hs_q[RD_LAT-2:0], hsync_in};
    vs_d = {vs_q[RD_LAT-2:0], vsync_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      clr_q   <= '0;
      cnt_q   <= '0;
      cx_q    <= CXW'(CANVAS_W/2);
      cy_q    <= CYW'(CANVAS_H/2);
      raddr_q <= '0;
      v_q     <= '0;
      hs_q    <= '1;
      vs_q    <= '1;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      cnt_q   <= cnt_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      raddr_q <= raddr_d;
      v_q     <= v_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
    end
  end

  canvas_ram #(
    .DEPTH(DEPTH),
    .AW   (AW),
    .DW   (COLOR_BITS)
  ) u_ram (
    .clk  (clk),
    .we   (we),
    .waddr(waddr),
    .wdata(wdata),
    .raddr(raddr_q),
    .rdata(rdata)
  );

`ifdef CURSOR_OVERLAY_EN
  logic [RD_LAT-1:0] m_q, m_d;

  always_comb begin
    m_d = {m_q[RD_LAT-2:0],
           pix_valid
           && (pix_x >> CELL_LOG2) == 10'(cx_q)
           && (pix_y >> CELL_LOG2) == 9'(cy_q)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_q <= '0;
    else        m_q <= m_d;
  end

  always_comb begin
    pix = m_q[RD_LAT-1] ? ~rdata : rdata;
    if (!v_q[RD_LAT-1]) pix = '0;
  end
`else
  always_comb begin
    pix = rdata;
    if (!v_q[RD_LAT-1]) pix = '0;
  end
`endif

  assign vga_r     = {4{pix[COLOR_BITS-1]}};
  assign vga_g     = {4{pix[COLOR_BITS-2]}};
  assign vga_b     = {4{pix[COLOR_BITS-3]}};
  assign hsync_out = hs_q[RD_LAT-1];
  assign vsync_out = vs_q[RD_LAT-1];
  assign cursor_x  = cx_q;
  assign cursor_y  = cy_q;
  assign busy      = (state_q == CLEAR);

endmodule

// File: tb/tb_canvas_painter.sv
// Randomised scoreboard bench for canvas_painter against a cell-array model.
module tb_canvas_painter;
  import painter_pkg::*;

  localparam int W     = 160;
  localparam int H     = 120;
  localparam int DEPTH = W * H;
  localparam int MD    = 4;
  localparam int PER   = 1 << MD;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_up = 0, btn_dn = 0, btn_lf = 0, btn_rt = 0;
  logic pen_down = 0;
  logic [2:0] pen_color = 0;
  logic clear_req = 0;
  logic [9:0] pix_x = 0;
  logic [8:0] pix_y = 0;
  logic pix_valid = 0;
  logic hsync_in = 1, vsync_in = 1;
  logic [3:0] vga_r, vga_g, vga_b;
  logic hsync_out, vsync_out;
  logic [7:0] cursor_x;
  logic [6:0] cursor_y;
  logic busy;

  always #5 clk = ~clk;

  canvas_painter #(.MOVE_DIV(MD)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_up(btn_up), .btn_dn(btn_dn),
    .btn_lf(btn_lf), .btn_rt(btn_rt),
    .pen_down(pen_down), .pen_color(pen_color),
    .clear_req(clear_req),
    .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .cursor_x(cursor_x), .cursor_y(cursor_y),
    .busy(busy)
  );

  int total = 0;
  int bad = 0;
  int gcnt = 0;

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  // Reference model: cursor as integers, canvas as a flat cell array.
  int mcx, mcy, mcnt, mclr;
  bit mbusy;
  logic [2:0] canvas [DEPTH];

  always @(posedge clk) gcnt++;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcx = W / 2; mcy = H / 2;
      mcnt = 0; mbusy = 1; mclr = 0;
    end else begin
      if (mbusy) begin
        mclr++;
        if (mclr == DEPTH) begin
          mbusy = 0;
          foreach (canvas[i]) canvas[i] = 3'b000;
        end
      end else begin
        if (mcnt == 0) begin
          mcx += int'(btn_rt) - int'(btn_lf);
          mcy += int'(btn_dn) - int'(btn_up);
          if (mcx < 0) mcx = 0;
          if (mcx > W - 1) mcx = W - 1;
          if (mcy < 0) mcy = 0;
          if (mcy > H - 1) mcy = H - 1;
          if (pen_down) canvas[mcy * W + mcx] = pen_color;
        end
        if (clear_req) begin
          mbusy = 1; mclr = 0;
        end
      end
      mcnt = (mcnt + 1) % PER;
    end
  end

  typedef struct {
    int due;
    logic [13:0] exp;
  } ent_t;
  ent_t q[$];
  ent_t me;

  always @(negedge clk) begin
    check("busy", busy, mbusy);
    check("cur_x", cursor_x, mcx);
    check("cur_y", cursor_y, mcy);
    while (q.size() > 0 && q[0].due <= gcnt) begin
      me = q.pop_front();
      check("pix", {vga_r, vga_g, vga_b, hsync_out, vsync_out}, me.exp);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic scan(input int x, input int y, input bit v);
    logic hs, vs;
    logic [2:0] c;
    ent_t e;
    hs = 1'($urandom);
    vs = 1'($urandom);
    pix_x = 10'(x); pix_y = 9'(y); pix_valid = v;
    hsync_in = hs; vsync_in = vs;
    c = 3'b000;
    if (v) begin
      c = canvas[(y >> 2) * W + (x >> 2)];
`ifdef CURSOR_OVERLAY_EN
      if ((x >> 2) == mcx && (y >> 2) == mcy) c = ~c;
`endif
    end
    e.due = gcnt + 2;
    e.exp = {{4{c[2]}}, {4{c[1]}}, {4{c[0]}}, hs, vs};
    q.push_back(e);
    step(1);
  endtask

  task automatic drain();
    pix_valid = 0; hsync_in = 1; vsync_in = 1;
    step(4);
  endtask

  task automatic scan_rand(input int n);
    bit v;
    for (int i = 0; i < n; i++) begin
      v = ($urandom % 8) != 0;
      if (v) scan($urandom % 640, $urandom % 480, 1'b1);
      else   scan($urandom % 1024, $urandom % 512, 1'b0);
    end
    scan(mcx * 4 + 2, mcy * 4 + 1, 1'b1);
    drain();
  endtask

  task automatic move(input bit rt, lf, up, dn, pen,
                      input logic [2:0] col, input int nt);
    int t;
    t = 0;
    btn_rt = rt; btn_lf = lf; btn_up = up; btn_dn = dn;
    pen_down = pen; pen_color = col;
    while (t < nt) begin
      if (mcnt == 0) t++;
      step(1);
    end
    btn_rt = 0; btn_lf = 0; btn_up = 0; btn_dn = 0;
    pen_down = 0;
  endtask

  task automatic wait_clear(input string nm, input bit req_mid);
    int n;
    n = 0;
    while (busy && n < 30000) begin
      clear_req = req_mid && (n == 100);
      step(1);
      n++;
    end
    clear_req = 0;
    check(nm, n, DEPTH);
  endtask

  initial begin
    step(3);
    check("rst_rgb", {vga_r, vga_g, vga_b}, 12'h000);
    check("rst_hs", hsync_out, 1'b1);
    check("rst_vs", vsync_out, 1'b1);
    check("rst_busy", busy, 1'b1);
    check("rst_cx", cursor_x, 80);
    check("rst_cy", cursor_y, 60);
    rst_n = 1;
    wait_clear("clr_len", 1'b0);
    scan_rand(1500);

    move(1, 0, 0, 0, 1, 3'b100, 3);
    check("cx_83", cursor_x, 83);
    for (int c = 80; c < 84; c++) scan(c * 4 + 1, 241, 1'b1);
    scan(324, 240, 1'b1);
    drain();

    move(1, 0, 0, 0, 0, 3'b000, 80);
    move(1, 0, 0, 0, 0, 3'b000, 2);
    check("cx_clamp", cursor_x, 159);
    move(0, 0, 1, 1, 0, 3'b000, 2);
    check("cy_cancel", cursor_y, 60);

    for (int r = 0; r < 6; r++) begin
      move(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 3'($urandom), 1 + $urandom % 20);
      scan_rand(300);
    end

    clear_req = 1;
    step(1);
    clear_req = 0;
    wait_clear("clr_req_len", 1'b1);
    scan_rand(200);

    move(0, 1, 1, 0, 1, 3'b011, 5);
    scan_rand(50);
    clear_req = 1;
    step(1);
    clear_req = 0;
    step(500);
    rst_n = 0;
    step(2);
    check("rst2_cx", cursor_x, 80);
    check("rst2_cy", cursor_y, 60);
    rst_n = 1;
    wait_clear("clr_restart", 1'b0);
    scan_rand(200);

    step(4);
    check("sb_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
